// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scancode parser: make/break/E0/E1 grammar, held-key map, timeout abort, and an event FIFO.
// Byte to ev_valid takes 1 cycle. A full FIFO with no pop drops the event and sets the sticky overflow flag.
module ps2_key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  output logic                       push_rdy,
  output logic                       pop_vld,
  input  logic                       pop_rdy,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, push, pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign pop_vld  = (cnt_q != '0);
  assign pop      = pop_vld & pop_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
  assign push_rdy = ~full | pop;
  assign push     = push_vld & push_rdy;
  assign pop_dat  = pop_vld ? mem_q[rd_q] : '0;
  assign count    = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_dat;
  end
endmodule

module ps2_key_event_queue #(
  parameter int FIFO_DEPTH     = 4,
  parameter int REPORT_RELEASE = 1,
  parameter int FILTER_REPEAT  = 1,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [7:0]                      received_data,
  input  logic                            received_data_en,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic [7:0]                      ev_code,
  output logic                            ev_ext,
  output logic                            ev_release,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  input  logic                            clear_overflow,
  output logic                            seq_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ev_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seq_err_q, seq_err_d;
  logic          ovf_q, ovf_d;
  logic [255:0]  held_q;

  logic          emit, emit_ext, emit_rel, enq, push_rdy;
  logic [7:0]    emit_code, idx;
  ev_t           push_ev, head_ev;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmo_d     = tmo_q;
    seq_err_d = 1'b0;
    emit      = 1'b0;
    emit_code = received_data;
    emit_ext  = 1'b0;
    emit_rel  = 1'b0;
    if (received_data_en) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          case (received_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          state_d = S_IDLE;
          if (received_data == 8'hF0) begin
            state_d = S_EXTBRK;
          end else if (received_data == 8'hE0 || received_data == 8'hE1) begin
            seq_err_d = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        S_BRK, S_EXTBRK: begin
          state_d = S_IDLE;
          if (received_data == 8'hF0 || received_data == 8'hE0 || received_data == 8'hE1) begin
            seq_err_d = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_rel = 1'b1;
            emit_ext = (state_q == S_EXTBRK);
          end
        end
        S_SKIP: begin
          // Pause is 8 bytes with no break form; report it once as extended make of E1.
          if (skip_q == 3'd1) begin
            state_d   = S_IDLE;
            emit      = 1'b1;
            emit_code = 8'hE1;
            emit_ext  = 1'b1;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = S_IDLE;
        tmo_d     = '0;
        seq_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign idx = {emit_ext, emit_code[6:0]};

  always_comb begin
    enq = 1'b0;
    if (emit) begin
      if (emit_rel) enq = (REPORT_RELEASE != 0);
      else          enq = !((FILTER_REPEAT != 0) && !emit_code[7] && held_q[idx]);
    end
  end

  assign ovf_d = (ovf_q & ~clear_overflow) | (enq & ~push_rdy);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
      // Codes with bit 7 set (e.g. pause) have no slot in the map.
      if (emit && !emit_code[7]) held_q[idx] <= ~emit_rel;
    end
  end

  assign push_ev = '{ext: emit_ext, rel: emit_rel, code: emit_code};

  ps2_key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(ev_t))
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst      (reset),
    .push_vld (enq),
    .push_dat (push_ev),
    .push_rdy (push_rdy),
    .pop_vld  (ev_valid),
    .pop_rdy  (ev_ready),
    .pop_dat  (head_ev),
    .count    (fifo_count)
  );

  assign ev_code    = head_ev.code;
  assign ev_ext     = head_ev.ext;
  assign ev_release = head_ev.rel;
  assign overflow   = ovf_q;
  assign seq_error  = seq_err_q;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed byte streams; expected events are queued per DUT and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_ps2_key_event_queue;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_dat = 8'h00;
  logic       rx_en = 1'b0;
  logic       ev_ready = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       dut2_on = 1'b0;

  logic       ev_valid, ev_ext, ev_release, overflow, seq_error;
  logic [7:0] ev_code;
  logic [2:0] fifo_count;

  logic       ev2_valid, ev2_ext, ev2_release, overflow2, seq_error2;
  logic [7:0] ev2_code;
  logic [2:0] fifo_count2;

  int checks = 0;
  int errors = 0;
  int seq_cnt = 0;
  logic [9:0] q[$];
  logic [9:0] q2[$];

  always #5 clk = ~clk;

  ps2_key_event_queue #(
    .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1), .FILTER_REPEAT(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .received_data(rx_dat), .received_data_en(rx_en),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_release(ev_release), .fifo_count(fifo_count), .overflow(overflow),
    .clear_overflow(clr_ovf), .seq_error(seq_error)
  );

  ps2_key_event_queue #(
    .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1), .FILTER_REPEAT(0), .TIMEOUT_CYCLES(TMO)
  ) dut2 (
    .CLOCK_50(clk), .reset(rst), .received_data(rx_dat), .received_data_en(rx_en & dut2_on),
    .ev_valid(ev2_valid), .ev_ready(1'b1), .ev_code(ev2_code), .ev_ext(ev2_ext),
    .ev_release(ev2_release), .fifo_count(fifo_count2), .overflow(overflow2),
    .clear_overflow(1'b0), .seq_error(seq_error2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    rx_dat = b;
    rx_en  = 1'b1;
    tick();
    rx_en  = 1'b0;
  endtask

  task automatic exp_ev(input logic [7:0] c, input logic e, input logic r);
    q.push_back({e, r, c});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() != 0 || q2.size() != 0); i++) tick();
    tick();
    chk("drain_q", q.size(), 0);
    chk("drain_q2", q2.size(), 0);
    chk("drain_count", fifo_count, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (seq_error) seq_cnt++;
      if (ev_valid && ev_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %h expected none at %0t",
                   {ev_ext, ev_release, ev_code}, $time);
        end else begin
          chk("event", {ev_ext, ev_release, ev_code}, q.pop_front());
        end
      end else if (!ev_valid) begin
        chk("empty_head", {ev_ext, ev_release, ev_code}, 0);
      end
      if (ev2_valid) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event2: got %h expected none at %0t",
                   {ev2_ext, ev2_release, ev2_code}, $time);
        end else begin
          chk("event2", {ev2_ext, ev2_release, ev2_code}, q2.pop_front());
        end
      end
    end
  end

  initial begin
    tick(); tick(); tick();
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_seqerr", seq_error, 0);
    rst = 1'b0;
    tick();

    exp_ev(8'h1C, 0, 0);
    send(8'h1C);
    chk("latency_valid", ev_valid, 1);
    drain();
    exp_ev(8'h1C, 0, 1);
    send(8'hF0); send(8'h1C);
    drain();

    // Extended key: second make while held is filtered, make after release is not.
    exp_ev(8'h75, 1, 0);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h75);
    exp_ev(8'h75, 1, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_ev(8'h75, 1, 0);
    send(8'hE0); send(8'h75);
    exp_ev(8'h75, 1, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    dut2_on = 1'b1;
    exp_ev(8'h1C, 0, 0);
    for (int i = 0; i < 3; i++) q2.push_back({1'b0, 1'b0, 8'h1C});
    send(8'h1C); send(8'h1C); send(8'h1C);
    exp_ev(8'h1C, 0, 1);
    q2.push_back({1'b0, 1'b1, 8'h1C});
    send(8'hF0); send(8'h1C);
    dut2_on = 1'b0;
    drain();

    exp_ev(8'hE1, 1, 0);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    drain();
    chk("pause_no_seqerr", seq_cnt, 0);

    send(8'hAA); send(8'hFA);
    exp_ev(8'h32, 0, 0);
    send(8'h32);
    exp_ev(8'h32, 0, 1);
    send(8'hF0); send(8'h32);
    drain();

    send(8'hE0); send(8'hE0);
    send(8'hF0); send(8'hE0);
    exp_ev(8'h2B, 0, 0);
    send(8'h2B);
    drain();
    chk("malformed_seqerr", seq_cnt, 2);

    send(8'hE0);
    for (int i = 0; i < TMO - 4; i++) tick();
    chk("timeout_early", seq_cnt, 2);
    for (int i = 0; i < 8; i++) tick();
    chk("timeout_fired", seq_cnt, 3);
    exp_ev(8'h1C, 0, 0);
    send(8'h1C);
    drain();

    // Overflow: five makes into four slots, then a simultaneous push and pop while full.
    ev_ready = 1'b0;
    exp_ev(8'h15, 0, 0); exp_ev(8'h16, 0, 0); exp_ev(8'h1D, 0, 0); exp_ev(8'h24, 0, 0);
    send(8'h15); send(8'h16); send(8'h1D); send(8'h24); send(8'h2D);
    chk("full_count", fifo_count, DEPTH);
    chk("ovf_set", overflow, 1);
    exp_ev(8'h2C, 0, 0);
    tick();
    rx_dat = 8'h2C; rx_en = 1'b1; ev_ready = 1'b1;
    tick();
    rx_en = 1'b0; ev_ready = 1'b0;
    chk("pushpop_count", fifo_count, DEPTH);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    ev_ready = 1'b1;
    drain();
    // Dropped 2D still marked held: its repeat make is filtered.
    send(8'h2D);
    exp_ev(8'h2D, 0, 1);
    send(8'hF0); send(8'h2D);
    drain();

    ev_ready = 1'b0;
    send(8'h3C); send(8'hE0);
    chk("pre_rst_count", fifo_count, 1);
    rst = 1'b1;
    tick(); tick();
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", ev_valid, 0);
    rst = 1'b0;
    ev_ready = 1'b1;
    exp_ev(8'h3C, 0, 0);
    send(8'h3C);
    exp_ev(8'h75, 0, 0);
    send(8'h75);
    drain();
    chk("final_seqerr", seq_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
